// File: rtl/apply_simple_case_arbiter.sv
// apply_simple_case_arbiter: round-robin sharing of one simple-case checker behind a one-deep tagged response stage
module apply_simple_case_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TYPE_W  = 3,
  parameter int INDEX_W = 30,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*TYPE_W-1:0]  req_type,
  input  logic [NUM_REQ*INDEX_W-1:0] req_f,
  input  logic [NUM_REQ*INDEX_W-1:0] req_g,
  output logic [TYPE_W-1:0]          chk_type,
  output logic [INDEX_W-1:0]         chk_f,
  output logic [INDEX_W-1:0]         chk_g,
  input  logic [TYPE_W-1:0]          chk_out_type,
  input  logic [INDEX_W-1:0]         chk_out_f,
  input  logic [INDEX_W-1:0]         chk_out_g,
  input  logic                       chk_hit,
  input  logic [INDEX_W-1:0]         chk_result,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [ID_W-1:0]            resp_id,
  output logic                       resp_hit,
  output logic [INDEX_W-1:0]         resp_result,
  output logic [TYPE_W-1:0]          resp_type,
  output logic [INDEX_W-1:0]         resp_f,
  output logic [INDEX_W-1:0]         resp_g,
  output logic [CNT_W-1:0]           hit_count,
  output logic [CNT_W-1:0]           miss_count
);
  localparam int RW = ID_W + 1 + 3 * INDEX_W + TYPE_W;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d, gnt_id;
  logic gnt_any, can_accept, xfer, resp_valid_q, resp_valid_d;
  logic [RW-1:0] resp_q, resp_d;
  logic [CNT_W-1:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;
  function automatic logic [ID_W-1:0] wrap(input int v);
    return ID_W'(v % NUM_REQ);
  endfunction
  always_comb begin
    gnt_any = 1'b0;
    gnt_id = rr_ptr_q;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req_valid[wrap(int'(rr_ptr_q) + k)]) begin
        gnt_any = 1'b1;
        gnt_id = wrap(int'(rr_ptr_q) + k);
      end
  end
  assign can_accept = reset_n & (~resp_valid_q | resp_ready);
  assign xfer = gnt_any & can_accept;
  assign req_ready = xfer ? NUM_REQ'(1) << gnt_id : '0;
  assign chk_type = req_type[int'(gnt_id) * TYPE_W +: TYPE_W];
  assign chk_f = req_f[int'(gnt_id) * INDEX_W +: INDEX_W];
  assign chk_g = req_g[int'(gnt_id) * INDEX_W +: INDEX_W];
  always_comb begin
    rr_ptr_d = xfer ? wrap(int'(gnt_id) + 1) : rr_ptr_q;
    resp_valid_d = xfer | (resp_valid_q & ~resp_ready);
    resp_d = xfer ? {gnt_id, chk_hit, chk_result, chk_out_type, chk_out_f, chk_out_g} : resp_q;
    hit_count_d = (xfer & chk_hit & ~&hit_count_q) ? hit_count_q + CNT_W'(1) : hit_count_q;
    miss_count_d = (xfer & ~chk_hit & ~&miss_count_q) ? miss_count_q + CNT_W'(1) : miss_count_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rr_ptr_q <= '0;
      resp_valid_q <= 1'b0;
      resp_q <= '0;
      hit_count_q <= '0;
      miss_count_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      resp_valid_q <= resp_valid_d;
      resp_q <= resp_d;
      hit_count_q <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  assign resp_valid = resp_valid_q;
  assign {resp_id, resp_hit, resp_result, resp_type, resp_f, resp_g} = resp_q;
  assign hit_count = hit_count_q;
  assign miss_count = miss_count_q;
endmodule

// File: tb/tb_apply_simple_case_arbiter.sv
// tb_apply_simple_case_arbiter: randomized scoreboard bench with a round-robin reference model and a stub checker
module tb_apply_simple_case_arbiter;
  localparam int N = 4;
  localparam logic [2:0] T_AND = 3'd1, T_ABS = 3'd4, T_EXIST = 3'd5;
  typedef struct packed {
    logic [1:0]  id;
    logic        hit;
    logic [29:0] res;
    logic [2:0]  ty;
    logic [29:0] f;
    logic [29:0] g;
  } rsp_t;
  logic clk = 1'b0, reset_n = 1'b0, rdy = 1'b0;
  logic [N-1:0] rv = '0;
  logic [N-1:0][2:0] ty = '0;
  logic [N-1:0][29:0] fv = '0, gv = '0;
  logic [N-1:0] req_ready;
  logic [2:0] chk_type, chk_out_type, resp_type;
  logic [29:0] chk_f, chk_g, chk_out_f, chk_out_g, chk_result, resp_result, resp_f, resp_g;
  logic chk_hit, resp_valid, resp_hit;
  logic [1:0] resp_id;
  logic [15:0] hit_count, miss_count;
  rsp_t chk_r, mon_e;
  rsp_t sb[$];
  int n_pass = 0, n_total = 0;
  int m_rr = 0, m_hit = 0, m_miss = 0, last_gnt = -1;
  bit m_valid = 1'b0;
  always #5 clk = ~clk;
  apply_simple_case_arbiter #(.NUM_REQ(N), .ID_W(2), .TYPE_W(3), .INDEX_W(30), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(rv), .req_ready(req_ready),
    .req_type(ty), .req_f(fv), .req_g(gv),
    .chk_type(chk_type), .chk_f(chk_f), .chk_g(chk_g),
    .chk_out_type(chk_out_type), .chk_out_f(chk_out_f), .chk_out_g(chk_out_g),
    .chk_hit(chk_hit), .chk_result(chk_result),
    .resp_valid(resp_valid), .resp_ready(rdy), .resp_id(resp_id), .resp_hit(resp_hit),
    .resp_result(resp_result), .resp_type(resp_type), .resp_f(resp_f), .resp_g(resp_g),
    .hit_count(hit_count), .miss_count(miss_count)
  );
  function automatic rsp_t chk_fn(logic [2:0] t, logic [29:0] f, logic [29:0] g);
    rsp_t r = '0;
    r.ty = t;
    r.f = f;
    r.g = g;
    if (t == T_AND && g == 30'd1) begin
      r.hit = 1'b1;
      r.res = f;
    end else if (t == T_ABS && f == 30'd1) begin
      r.ty = T_EXIST;
      r.f = g;
      r.g = '0;
    end else begin
      r.hit = f[0] ^ g[0];
      r.res = f ^ g;
      r.f = g;
      r.g = f;
    end
    return r;
  endfunction
  assign chk_r = chk_fn(chk_type, chk_f, chk_g);
  assign chk_hit = chk_r.hit;
  assign chk_result = chk_r.res;
  assign chk_out_type = chk_r.ty;
  assign chk_out_f = chk_r.f;
  assign chk_out_g = chk_r.g;
  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask
  always @(negedge clk)
    if (reset_n && resp_valid && rdy) begin
      if (sb.size() == 0) check("resp_unexpected", 64'(resp_valid), 64'(0));
      else begin
        mon_e = sb.pop_front();
        check("resp_id", 64'(resp_id), 64'(mon_e.id));
        check("resp_hit", 64'(resp_hit), 64'(mon_e.hit));
        check("resp_result", 64'(resp_result), 64'(mon_e.res));
        check("resp_type", 64'(resp_type), 64'(mon_e.ty));
        check("resp_f", 64'(resp_f), 64'(mon_e.f));
        check("resp_g", 64'(resp_g), 64'(mon_e.g));
      end
    end
  task automatic step();
    int gi = -1;
    bit acc;
    logic [N-1:0] er;
    rsp_t e;
    @(negedge clk);
    for (int k = 0; k < N; k++)
      if (gi < 0 && rv[(m_rr + k) % N]) gi = (m_rr + k) % N;
    acc = gi >= 0 && (!m_valid || rdy);
    er = acc ? N'(1) << gi : '0;
    check("req_ready", 64'(req_ready), 64'(er));
    check("resp_valid", 64'(resp_valid), 64'(m_valid));
    check("hit_count", 64'(hit_count), 64'(m_hit));
    check("miss_count", 64'(miss_count), 64'(m_miss));
    last_gnt = acc ? gi : -1;
    if (acc) begin
      e = chk_fn(ty[gi], fv[gi], gv[gi]);
      e.id = 2'(gi);
      sb.push_back(e);
      if (e.hit) m_hit = (m_hit == 65535) ? 65535 : m_hit + 1;
      else m_miss = (m_miss == 65535) ? 65535 : m_miss + 1;
      m_rr = (gi + 1) % N;
    end
    m_valid = acc || (m_valid && !rdy);
    @(posedge clk);
    #1;
  endtask
  task automatic refill(int pct);
    for (int i = 0; i < N; i++)
      if (!rv[i] || last_gnt == i) begin
        rv[i] = $urandom_range(99) < pct;
        ty[i] = 3'($urandom_range(7));
        fv[i] = ($urandom_range(3) == 0) ? 30'd1 : 30'($urandom);
        gv[i] = ($urandom_range(3) == 0) ? 30'd1 : 30'($urandom);
      end
  endtask
  initial begin
    rdy = 1'b1;
    rv = 4'b0001;
    repeat (3) @(posedge clk);
    #1;
    check("reset_req_ready", 64'(req_ready), 64'(0));
    check("reset_resp_valid", 64'(resp_valid), 64'(0));
    rv = '0;
    reset_n = 1'b1;
    repeat (2) step();
    rv[2] = 1'b1;
    ty[2] = T_AND;
    fv[2] = 30'd5;
    gv[2] = 30'd1;
    step();
    rv[2] = 1'b0;
    check("single_id", 64'(resp_id), 64'(2));
    check("single_result", 64'(resp_result), 64'(5));
    check("single_hit_count", 64'(hit_count), 64'(1));
    repeat (2) step();
    rv = '1;
    repeat (6) step();
    rdy = 1'b0;
    rv = 4'b1010;
    repeat (5) step();
    rdy = 1'b1;
    repeat (3) begin
      step();
      if (last_gnt >= 0) rv[last_gnt] = 1'b0;
    end
    rv = '0;
    rv[0] = 1'b1;
    ty[0] = T_ABS;
    fv[0] = 30'd1;
    gv[0] = 30'd7;
    step();
    rv[0] = 1'b0;
    check("xform_type", 64'(resp_type), 64'(T_EXIST));
    check("xform_f", 64'(resp_f), 64'(7));
    check("xform_hit", 64'(resp_hit), 64'(0));
    repeat (2) step();
    repeat (3000) begin
      rdy = $urandom_range(3) != 0;
      step();
      refill(60);
    end
    rdy = 1'b1;
    rv = '0;
    rv[0] = 1'b1;
    ty[0] = T_AND;
    fv[0] = 30'd9;
    gv[0] = 30'd1;
    while (m_hit < 65535) step();
    repeat (3) step();
    check("hit_saturated", 64'(hit_count), 64'(16'hFFFF));
    #2;
    reset_n = 1'b0;
    #1;
    check("async_resp_valid", 64'(resp_valid), 64'(0));
    check("async_req_ready", 64'(req_ready), 64'(0));
    check("async_hit_count", 64'(hit_count), 64'(0));
    sb.delete();
    m_valid = 1'b0;
    m_rr = 0;
    m_hit = 0;
    m_miss = 0;
    rv = '0;
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    rv = 4'b1000;
    ty[3] = T_AND;
    fv[3] = 30'd3;
    gv[3] = 30'd1;
    step();
    rv = '0;
    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
